// File: rtl/ps_lane_tx_scheduler.sv
// Lane TX byte sequencer: idle COM fill, COM sync burst on activation, then drains a show-ahead FIFO.
// Latency 1 cycle fifo_data->data_out; fifo_pop is combinational and never asserts when active=0.
// Optional skip-symbol insertion is enabled by defining PS_SKP_INSERT_EN.
module ps_lane_tx_scheduler #(
    parameter int            DW           = 8,
    parameter int            SYNC_LEN     = 4,
    parameter int            IDL_THR      = 2,
    parameter logic [DW-1:0] COM          = 8'hBC,
    parameter logic [DW-1:0] SKP          = 8'h1C,
    parameter int            SKP_INTERVAL = 16
) (
    input  logic          clk_4f,
    input  logic          reset_L,
    input  logic          active,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_pop,
    output logic [DW-1:0] data_out,
    output logic          valid_out,
    output logic          IDL,
    output logic [1:0]    state
);

    localparam int MAX_AB = (SYNC_LEN > IDL_THR) ? SYNC_LEN : IDL_THR;
    localparam int MAXP   = (MAX_AB > SKP_INTERVAL) ? MAX_AB : SKP_INTERVAL;
    localparam int CW     = $clog2(MAXP) + 1;
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
    localparam logic [CW-1:0] IDL_LIM   = CW'(IDL_THR);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SYNC  = 2'd2,
        ST_DATA  = 2'd3
    } state_t;

    state_t        cur_state;
    state_t        nxt_state;
    logic [CW-1:0] sync_cnt;
    logic [CW-1:0] sync_nxt;
    logic [CW-1:0] empty_cnt;
    logic [CW-1:0] empty_nxt;
    logic [CW-1:0] empty_inc;
    logic [DW-1:0] data_nxt;
    logic          valid_nxt;
    logic          idl_nxt;
    logic          skip_due;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

`ifdef PS_SKP_INSERT_EN
    localparam logic [CW-1:0] SKP_LAST = CW'(SKP_INTERVAL);
    logic [CW-1:0] skip_cnt;
    logic [CW-1:0] skip_nxt;

    assign skip_due = (cur_state == ST_DATA) && (skip_cnt == SKP_LAST);

    // Counts popped bytes only; cleared whenever the lane is not in DATA.
    always_comb begin
        skip_nxt = '0;
        if (cur_state == ST_DATA && active) begin
            if (skip_due)      skip_nxt = '0;
            else if (fifo_pop) skip_nxt = sat_inc(skip_cnt);
            else               skip_nxt = skip_cnt;
        end
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) skip_cnt <= '0;
        else          skip_cnt <= skip_nxt;
    end
`else
    assign skip_due = 1'b0;
`endif

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            cur_state <= ST_RESET;
            data_out  <= '0;
            valid_out <= 1'b0;
            IDL       <= 1'b1;
            sync_cnt  <= '0;
            empty_cnt <= '0;
        end else begin
            cur_state <= nxt_state;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
            IDL       <= idl_nxt;
            sync_cnt  <= sync_nxt;
            empty_cnt <= empty_nxt;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_RESET: nxt_state = ST_IDLE;
            ST_IDLE:  nxt_state = active ? ST_SYNC : ST_IDLE;
            ST_SYNC:  nxt_state = !active ? ST_IDLE :
                                  (sync_cnt == SYNC_LAST) ? ST_DATA : ST_SYNC;
            ST_DATA:  nxt_state = active ? ST_DATA : ST_IDLE;
            default:  nxt_state = ST_RESET;
        endcase
    end

    // Defaults are the idle-fill outputs; leaving SYNC/DATA on active=0 falls through to them.
    always_comb begin
        fifo_pop  = 1'b0;
        data_nxt  = COM;
        valid_nxt = 1'b0;
        idl_nxt   = 1'b1;
        sync_nxt  = '0;
        empty_nxt = '0;
        empty_inc = sat_inc(empty_cnt);
        case (cur_state)
            ST_RESET: data_nxt = '0;
            ST_SYNC: begin
                if (active) begin
                    valid_nxt = 1'b1;
                    sync_nxt  = sat_inc(sync_cnt);
                end
            end
            ST_DATA: begin
                if (active) begin
                    if (skip_due) begin
                        data_nxt  = SKP;
                        valid_nxt = 1'b1;
                        idl_nxt   = IDL;
                        empty_nxt = empty_cnt;
                    end else if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        data_nxt  = fifo_data;
                        valid_nxt = 1'b1;
                        idl_nxt   = 1'b0;
                    end else begin
                        empty_nxt = empty_inc;
                        idl_nxt   = (empty_inc >= IDL_LIM) ? 1'b1 : IDL;
                    end
                end
            end
            default: ;
        endcase
    end

    assign state = cur_state;

endmodule

// File: tb/tb_ps_lane_tx_scheduler.sv
// Randomized bench for ps_lane_tx_scheduler against a queue-based behavioural lane model.
module tb_ps_lane_tx_scheduler;

    localparam int          DW           = 8;
    localparam int          SYNC_LEN     = 4;
    localparam int          IDL_THR      = 2;
    localparam int          SKP_INTERVAL = 16;
    localparam logic [7:0]  COM          = 8'hBC;
    localparam logic [7:0]  SKP          = 8'h1C;

    logic       clk_4f     = 1'b0;
    logic       reset_L    = 1'b0;
    logic       active     = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = '0;
    logic       fifo_pop;
    logic [7:0] data_out;
    logic       valid_out;
    logic       IDL;
    logic [1:0] state;

    always #5 clk_4f = ~clk_4f;

    ps_lane_tx_scheduler #(
        .DW(DW), .SYNC_LEN(SYNC_LEN), .IDL_THR(IDL_THR),
        .COM(COM), .SKP(SKP), .SKP_INTERVAL(SKP_INTERVAL)
    ) dut (
        .clk_4f(clk_4f), .reset_L(reset_L), .active(active),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .data_out(data_out), .valid_out(valid_out), .IDL(IDL), .state(state)
    );

    int n_chk = 0;
    int n_err = 0;

    // Bytes waiting in the FIFO, head first.
    logic [7:0] fq[$];

    // Lane model: phase numbers are the debug encoding (0 reset, 1 idle, 2 sync, 3 data).
    int         ph;
    int         sync_sent;
    int         empty_run;
    int         since_skip;
    logic [7:0] e_data;
    logic       e_valid;
    logic       e_idl;
    logic       e_pop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic skip_now();
`ifdef PS_SKP_INSERT_EN
        return (ph == 3) && (since_skip == SKP_INTERVAL);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        ph = 0; e_data = 8'h00; e_valid = 1'b0; e_idl = 1'b1;
        sync_sent = 0; empty_run = 0; since_skip = 0;
    endtask

    task automatic model_idle();
        ph = 1; e_data = COM; e_valid = 1'b0; e_idl = 1'b1;
        empty_run = 0; since_skip = 0;
    endtask

    task automatic model_edge();
        case (ph)
            0: ph = 1;
            1: begin
                model_idle();
                if (active) begin ph = 2; sync_sent = 0; end
            end
            2: begin
                if (!active) model_idle();
                else begin
                    e_data = COM; e_valid = 1'b1; e_idl = 1'b1;
                    sync_sent++;
                    if (sync_sent == SYNC_LEN) begin ph = 3; empty_run = 0; since_skip = 0; end
                end
            end
            default: begin
                if (!active) model_idle();
                else if (skip_now()) begin
                    e_data = SKP; e_valid = 1'b1; since_skip = 0;
                end else if (e_pop) begin
                    e_data = fq.pop_front(); e_valid = 1'b1; e_idl = 1'b0;
                    empty_run = 0; since_skip++;
                end else begin
                    e_data = COM; e_valid = 1'b0; empty_run++;
                    if (empty_run >= IDL_THR) e_idl = 1'b1;
                end
            end
        endcase
    endtask

    // One clock: check registered outputs, drive inputs on the falling edge, check pop, advance model.
    task automatic step(input logic rst, input logic act, input logic hold_empty);
        @(negedge clk_4f);
        check("data_out", data_out, e_data);
        check("valid_out", valid_out, e_valid);
        check("IDL", IDL, e_idl);
        check("state", state, ph);
        reset_L    = rst;
        active     = act;
        fifo_empty = hold_empty || (fq.size() == 0);
        fifo_data  = fifo_empty ? 8'($urandom) : fq[0];
        if (!rst) model_reset();
        e_pop = rst && (ph == 3) && act && !fifo_empty && !skip_now();
        #1;
        check("fifo_pop", fifo_pop, e_pop);
        if (!rst) begin
            check("arst_data", data_out, 0);
            check("arst_valid", valid_out, 0);
            check("arst_idl", IDL, 1);
            check("arst_state", state, 0);
        end
        @(posedge clk_4f);
        if (rst) model_edge();
    endtask

    logic act_r;
    logic rst_r;

    initial begin
        model_reset();
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b0, 1'b0);

        for (int i = 1; i <= 6; i++) fq.push_back(8'(i));
        repeat (13) step(1'b1, 1'b1, 1'b0);
        fq.push_back(8'hA5);
        repeat (2) step(1'b1, 1'b1, 1'b0);

        // Drop active with a byte pending; it must survive until after the next sync burst.
        fq.push_back(8'hB0);
        fq.push_back(8'hB1);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) fq.push_back(8'(8'hC0 + i));
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0);

        act_r = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 0 && fq.size() < 48) fq.push_back(8'($urandom));
            if ($urandom_range(0, 49) == 0) act_r = !act_r;
            rst_r = ($urandom_range(0, 299) != 0);
            step(rst_r, act_r, ($urandom_range(0, 3) == 0));
        end
        step(1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
